// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and FSM state type for the mem_resp responder
package mem_pkg;
  localparam int DefAddrWidth = 5;
  localparam int DefDataWidth = 8;
  localparam int CntWidth     = 16;

  typedef enum logic {SCRUB, RUN} state_e;
endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single write port storage with a registered read port
module mem_array #(
  parameter int AddrWidth = 5,
  parameter int DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 re,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);
  logic [DataWidth-1:0] mem [0:(1<<AddrWidth)-1];

  // Storage has no reset; the owner clears it by scrubbing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - scrubbing memory responder; MEM_RESP_STATS_EN adds rd_cnt/wr_cnt
module mem_resp
  import mem_pkg::*;
#(
  parameter int AddrWidth = DefAddrWidth,
  parameter int DataWidth = DefDataWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] data_in,
  input  logic                 read,
  input  logic                 write,
  output logic [DataWidth-1:0] data_out,
  output logic                 ready,
  output logic                 err
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [CntWidth-1:0]  rd_cnt,
  output logic [CntWidth-1:0]  wr_cnt
`endif
);
  state_e               state;
  logic [AddrWidth-1:0] ptr;
  logic                 in_scrub;
  logic                 rd_acc;
  logic                 wr_acc;
  logic                 we;
  logic [AddrWidth-1:0] waddr;
  logic [DataWidth-1:0] wdata;

  assign in_scrub = (state == SCRUB);
  assign rd_acc   = !in_scrub && read && !write;
  assign wr_acc   = !in_scrub && write && !read;

  // During scrub the array write port belongs to the pointer, not the initiator.
  assign we    = in_scrub || wr_acc;
  assign waddr = in_scrub ? ptr : addr;
  assign wdata = in_scrub ? '0 : data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCRUB;
      ptr   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= in_scrub ? (read || write) : (read && write);
      case (state)
        SCRUB: begin
          if (&ptr) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            ptr <= ptr + AddrWidth'(1);
          end
        end
        RUN: ready <= 1'b1;
        default: state <= SCRUB;
      endcase
    end
  end

  mem_array #(
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (rd_acc),
    .raddr(addr),
    .rdata(data_out)
  );

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_acc && rd_cnt != '1) rd_cnt <= rd_cnt + CntWidth'(1);
      if (wr_acc && wr_cnt != '1) wr_cnt <= wr_cnt + CntWidth'(1);
    end
  end
`endif
endmodule

// File: tb/tb_mem_resp.sv
// tb/tb_mem_resp.sv - directed self-checking bench for mem_resp
module tb_mem_resp;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [7:0] data_out;
  logic       ready;
  logic       err;
`ifdef MEM_RESP_STATS_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_resp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .data_in (data_in),
    .read    (read),
    .write   (write),
    .data_out(data_out),
    .ready   (ready),
    .err     (err)
`ifdef MEM_RESP_STATS_EN
    ,
    .rd_cnt  (rd_cnt),
    .wr_cnt  (wr_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = data_out;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Rising edges after release: ready must stay low for 31, rise on the 32nd.
  task automatic wait_scrub();
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      chk($sformatf("ready_e%0d", i), ready, (i == 32));
    end
  endtask

  logic [7:0] rd;

  initial begin
    #1;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_ready", ready, 1'b0);
    chk("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_scrub();

    for (int a = 0; a < 32; a++) begin
      do_read(5'(a), rd);
      chk($sformatf("scrub_zero_%0d", a), rd, 8'h00);
    end

    do_write(5'd3, 8'hA5);
    do_read(5'd3, rd);
    chk("rd_a3", rd, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_a5", data_out, 8'hA5);
    end

    do_write(5'd0, 8'h11);
    do_write(5'd31, 8'hEE);
    do_read(5'd0, rd);
    chk("rd_a0", rd, 8'h11);
    do_read(5'd31, rd);
    chk("rd_a31", rd, 8'hEE);
    do_read(5'd30, rd);
    chk("rd_a30", rd, 8'h00);

    // Write then read of the same address on consecutive edges.
    @(negedge clk);
    addr = 5'd9; data_in = 8'h3C; write = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    chk("wr_rd_b2b", data_out, 8'h3C);

    @(negedge clk);
    addr = 5'd7; data_in = 8'h55; read = 1'b1; write = 1'b1;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    chk("coll_err", err, 1'b1);
    chk("coll_dout", data_out, 8'h3C);
    @(negedge clk);
    chk("coll_err_clr", err, 1'b0);
    do_read(5'd7, rd);
    chk("coll_mem7", rd, 8'h00);

    // Strobe during scrub at edge 10.
    do_reset();
    repeat (9) @(negedge clk);
    addr = 5'd2; data_in = 8'h77; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    chk("scrub_err", err, 1'b1);
    chk("scrub_rdy10", ready, 1'b0);
    repeat (21) @(negedge clk);
    chk("scrub_rdy31", ready, 1'b0);
    @(negedge clk);
    chk("scrub_rdy32", ready, 1'b1);
    chk("scrub_err_clr", err, 1'b0);
    do_read(5'd2, rd);
    chk("scrub_wr_ign", rd, 8'h00);

    do_write(5'd4, 8'h42);
    do_read(5'd4, rd);
    chk("rd_a4", rd, 8'h42);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", data_out, 8'h00);
    chk("mid_rst_ready", ready, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_scrub();
    do_read(5'd4, rd);
    chk("rerun_a4", rd, 8'h00);

`ifdef MEM_RESP_STATS_EN
    do_reset();
    repeat (32) @(negedge clk);
    chk("st_rst_rd", rd_cnt, 16'd0);
    chk("st_rst_wr", wr_cnt, 16'd0);
    do_write(5'd1, 8'h01);
    do_write(5'd2, 8'h02);
    do_write(5'd3, 8'h03);
    do_read(5'd1, rd);
    do_read(5'd2, rd);
    @(negedge clk);
    read = 1'b1; write = 1'b1;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    chk("st_wr", wr_cnt, 16'd3);
    chk("st_rd", rd_cnt, 16'd2);
    @(negedge clk);
    read = 1'b1;
    repeat (70000) @(negedge clk);
    read = 1'b0;
    chk("st_rd_sat", rd_cnt, 16'hFFFF);
    chk("st_wr_after", wr_cnt, 16'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_resp.md
# mem_resp

Responder end of the `mem_intf` memory protocol: a 2**AddrWidth x DataWidth synchronous memory that serves the `mem` modport for the `tb` modport's `write_mem`/`read_mem` tasks. After reset it runs a hardware scrub that zeroes every location. It then accepts single-cycle read and write strobes sampled on the rising clock edge. It sits directly behind the interface instance in the lab testbench and replaces the behavioural memory.

## Interface
- AddrWidth, 5, address width; depth is 2**AddrWidth.
- DataWidth, 8, data word width.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- addr  input  AddrWidth  access address.
- data_in  input  DataWidth  write data.
- read  input  1  read strobe, one cycle.
- write  input  1  write strobe, one cycle.
- data_out  output  DataWidth  registered read data.
- ready  output  1  high once the scrub has completed.
- err  output  1  one-cycle pulse flagging a rejected access.
- rd_cnt, wr_cnt  output  16 each  access counters; present only with `MEM_RESP_STATS_EN`.

## Operation
- FSM states are SCRUB and RUN. Reset forces SCRUB and sets the scrub pointer to 0.
- SCRUB:
  - Each cycle, write 0 to mem[ptr] and increment ptr.
  - When ptr == 2**AddrWidth-1 has been written, go to RUN.
  - Scrub takes exactly 2**AddrWidth cycles (32 at defaults). ptr must not wrap.
- RUN:
  - write=1, read=0: mem[addr] <= data_in.
  - read=1, write=0: data_out <= mem[addr], the value before any same-edge write.
  - data_out holds its value until the next accepted read.
  - read=1 and write=1 (collision): no memory or data_out change; err=1 for one cycle.
  - Neither strobe high: no change.
- A strobe seen in SCRUB is ignored and pulses err. The scrub is neither stalled nor restarted.
- A read following a write to the same address on the next edge returns the new data.
- Reset mid-scrub or mid-run:
  - ready=0, data_out=0, err=0, counters=0, state=SCRUB, ptr=0.
  - Memory contents are not cleared by reset itself; the scrub clears them.

## Timing
- Reset values: data_out=0, ready=0, err=0, rd_cnt=0, wr_cnt=0.
- The initiator drives strobes on the falling edge. The responder samples at the following rising edge.
- Read latency is 1 edge: data_out is valid after the sampling edge. The initiator reads it at the next falling edge.
- Write takes effect at the sampling edge.
- ready rises on the edge that writes the last scrub location, i.e. the 32nd edge after reset release.
- err is registered: it is high for the one cycle after the offending edge.
- Back-to-back strobes on consecutive edges are fully supported, with no bubble required.

## Configuration
- Macro: `MEM_RESP_STATS_EN`.
- Defined:
  - rd_cnt counts accepted reads and wr_cnt counts accepted writes, each +1 on the accepting edge.
  - Both saturate at 16'hFFFF.
  - Collisions, SCRUB-time strobes and scrub writes are not counted.
- Undefined: rd_cnt and wr_cnt ports and their logic are absent. All other behaviour is identical.

## Structure
- `mem_pkg`: default AddrWidth/DataWidth localparams, the `state_e` enum {SCRUB, RUN}, and the counter width localparam (16).
- Sub-module `mem_array`: a single-port-write/registered-read storage array with we, waddr, wdata, re, raddr, rdata. `mem_resp` owns the FSM, the scrub mux, error detection and the counters.

## Test plan
- Reset release, then poll ready -> ready=0 for 31 edges, 1 on the 32nd. A read of every address returns 0.
- `write_mem(5'd3, 8'hA5)` then `read_mem(5'd3)` -> rdata=8'hA5. data_out holds A5 through 3 idle cycles.
- Write 8'h11 to address 0 and 8'hEE to address 31 (boundary addresses), then read both -> 8'h11 and 8'hEE. Address 30 still reads 0.
- read and write driven together at addr 7 with data 8'h55 -> err pulses for 1 cycle, mem[7] stays 0, data_out is unchanged.
- Write strobe at cycle 10 of the scrub -> err pulse, ready still rises at edge 32. Then assert rst_n=0 mid-run after writing 8'h42 to address 4 -> all outputs return to 0, scrub reruns, address 4 reads 0.
- With `MEM_RESP_STATS_EN`: 3 writes, 2 reads and 1 collision -> wr_cnt=3, rd_cnt=2. 70000 reads -> rd_cnt saturates at 16'hFFFF.
